// File: rtl/stpmtr_sched.sv
// Round-robin scheduler sharing one stepper-motor position port between NREQ requesters.
// Optional motor-ack watchdog enabled by defining STPMTR_SCHED_TIMEOUT_EN.
module stpmtr_sched #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned MAX_POS = 240,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [8*NREQ-1:0]    req_pos_i,
  input  logic [NREQ-1:0]      req_valid_i,
  output logic [NREQ-1:0]      req_ack_o,
  output logic [NREQ-1:0]      req_err_o,
  output logic [2:0]           grant_o,
  output logic                 busy_o,
  output logic [7:0]           mtr_pos_o,
  output logic                 mtr_valid_o,
  input  logic                 mtr_ack_i
);

  localparam int unsigned PW = 8;
  localparam int unsigned GW = 3;
  localparam int unsigned CW = 16;
  localparam logic [PW-1:0] MAX_P = PW'(MAX_POS);

  if ((NREQ < 2) || (NREQ > 8) || (TIMEOUT < 2) || (TIMEOUT > 65535)) begin : g_param_check
    $error("stpmtr_sched: NREQ or TIMEOUT out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t          r_state;
  logic [GW-1:0]   r_last;
  logic            w_found;
  logic [GW-1:0]   w_win;
  logic [GW-1:0]   w_idx;
  logic [PW-1:0]   w_pos;
  logic [NREQ-1:0] w_win_oh;
  logic [NREQ-1:0] w_grant_oh;

`ifdef STPMTR_SCHED_TIMEOUT_EN
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] r_cnt;
`endif

  // Round-robin search starting one past the last served requester
  always_comb begin
    w_found = 1'b0;
    w_win   = r_last;
    w_idx   = r_last;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      w_idx = GW'((32'(r_last) + i) % NREQ);
      if (!w_found && (|(req_valid_i & (NREQ'(1) << w_idx)))) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_pos      = PW'(req_pos_i >> (PW * w_win));
  assign w_win_oh   = NREQ'(1) << w_win;
  assign w_grant_oh = NREQ'(1) << grant_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_last      <= GW'(NREQ - 1);
      req_ack_o   <= '0;
      req_err_o   <= '0;
      grant_o     <= '0;
      busy_o      <= 1'b0;
      mtr_pos_o   <= '0;
      mtr_valid_o <= 1'b0;
`ifdef STPMTR_SCHED_TIMEOUT_EN
      r_cnt       <= '0;
`endif
    end else begin
      req_ack_o <= '0;
      req_err_o <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_last  <= w_win;
            grant_o <= w_win;
            busy_o  <= 1'b1;
            if (w_pos > MAX_P) begin
              // Out-of-range target is answered immediately, never reaches the motor
              req_ack_o <= w_win_oh;
              req_err_o <= w_win_oh;
              r_state   <= S_GAP;
            end else begin
              mtr_pos_o   <= w_pos;
              mtr_valid_o <= 1'b1;
              r_state     <= S_ISSUE;
`ifdef STPMTR_SCHED_TIMEOUT_EN
              r_cnt       <= '0;
`endif
            end
          end
        end
        S_ISSUE: begin
          if (mtr_ack_i) begin
            mtr_valid_o <= 1'b0;
            req_ack_o   <= w_grant_oh;
            r_state     <= S_GAP;
          end
`ifdef STPMTR_SCHED_TIMEOUT_EN
          // Ack arriving on the final count takes priority over the watchdog
          else if (r_cnt == TO_LAST) begin
            mtr_valid_o <= 1'b0;
            req_ack_o   <= w_grant_oh;
            req_err_o   <= w_grant_oh;
            r_state     <= S_GAP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
`endif
        end
        S_GAP: begin
          busy_o  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy_o      <= 1'b0;
          mtr_valid_o <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/stpmtr_sched.md
# stpmtr_sched

Round-robin command scheduler that shares one stepper-motor position interface between NREQ requesters. Each requester presents an absolute target position with a valid/ack handshake. The scheduler range-checks the target, issues it to the motor controller's `pos_i`/`valid` port and waits for the motor's `ack`. It then returns a one-cycle acknowledge to the winning requester. It sits between the application-side command sources and the stepper-motor controller, on the same 1 kHz clock.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `MAX_POS`, 240: highest legal absolute position; larger targets are rejected.
- `TIMEOUT`, 1000: motor-ack watchdog limit in cycles, 2..65535. Used only with `STPMTR_SCHED_TIMEOUT_EN`.
- `clk_i` in 1: system clock (1 kHz).
- `rst_i` in 1: synchronous, active-high reset.
- `req_pos_i` in 8*NREQ: target positions; requester k uses bits [8k+7:8k].
- `req_valid_i` in NREQ: request pending, one bit per requester.
- `req_ack_o` out NREQ: one-cycle completion pulse to the served requester.
- `req_err_o` out NREQ: one-cycle error flag, coincident with `req_ack_o`.
- `grant_o` out 3: index of the requester currently or last served.
- `busy_o` out 1: high in ISSUE and GAP.
- `mtr_pos_o` out 8: target position to the motor controller `pos_i`.
- `mtr_valid_o` out 1: command valid to the motor controller `valid`.
- `mtr_ack_i` in 1: motor controller `ack`. It pulses when the command is accepted, which happens only once the previous motion is complete.

## Operation
- **States:** IDLE, ISSUE, GAP.
- **Round-robin pointer `last`:** the search starts at `last+1` and wraps modulo NREQ. The first set `req_valid_i` bit wins.
- **IDLE, no valid bits set:** stay in IDLE.
- **IDLE, winner k with `req_pos_i[k] > MAX_POS`:**
  - Pulse `req_ack_o[k]` and `req_err_o[k]` for one cycle.
  - Set `last <= k` and `grant_o <= k`.
  - Go to GAP. No motor command is issued.
- **IDLE, winner k in range:**
  - Register `mtr_pos_o <= req_pos_i[k]` and set `mtr_valid_o <= 1`.
  - Set `last <= k` and `grant_o <= k`.
  - Go to ISSUE.
- **ISSUE:**
  - Hold `mtr_valid_o` high and `mtr_pos_o` stable.
  - When `mtr_ack_i` is sampled high: clear `mtr_valid_o`, pulse `req_ack_o[grant]` (no error), go to GAP.
- **GAP:** one cycle only, then IDLE. This guarantees that `mtr_valid_o` is low for at least one cycle between commands, and gives the requester one edge to drop `req_valid_i`.
- **Requester contract:**
  - Hold `req_valid_i[k]` and `req_pos_i[k]` stable until `req_ack_o[k]` is seen.
  - Deassert `req_valid_i[k]` on the edge at which `req_ack_o[k]` is seen; otherwise it is treated as a new request.
- **Request dropped early:** a requester that drops `req_valid_i` after being granted does not cancel the issued command. The ack is still delivered.
- `mtr_ack_i` is ignored outside ISSUE.
- `req_pos_i` changes in ISSUE and GAP are ignored.
- Only one bit of `req_ack_o` is ever high at a time.

## Timing
- **Reset values:** all outputs are 0 (`req_ack_o`, `req_err_o`, `grant_o`, `busy_o`, `mtr_pos_o`, `mtr_valid_o`). `last` resets to NREQ-1, so requester 0 has first priority. State resets to IDLE.
- **Reset mid-operation:** reset in any state returns to IDLE within one edge. `mtr_valid_o` drops with no ack and no error; the pending request is re-arbitrated after reset.
- **Request to motor:** `mtr_valid_o` rises 1 cycle after a valid request is sampled in IDLE.
- **Motor ack to requester:** `req_ack_o` rises 1 cycle after `mtr_ack_i` is sampled.
- **Rejected request:** `req_ack_o`/`req_err_o` rise 1 cycle after the request is sampled.
- **Back-to-back requests:** a new command can be issued no sooner than 2 cycles after an ack (GAP, then IDLE evaluation).
- **Simultaneous requests:** exactly one wins per IDLE evaluation. With all NREQ requesters continuously valid, grants rotate 0,1,2,…,NREQ-1,0.
- **Position comparison:** unsigned 8-bit. MAX_POS itself is legal; 255 is rejected.

## Configuration
- `STPMTR_SCHED_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to ISSUE and increments each ISSUE cycle.
  - When it reaches TIMEOUT with no `mtr_ack_i`: `mtr_valid_o <= 0`, pulse `req_ack_o[grant]` and `req_err_o[grant]`, go to GAP.
  - If `mtr_ack_i` arrives in the same cycle the count reaches TIMEOUT, the ack wins and no error is flagged.
- Undefined: no counter. ISSUE waits indefinitely for `mtr_ack_i`.

## Test plan
- **Reset:** hold `rst_i` for 3 cycles with all requests asserted -> all outputs 0 throughout. Requester 0 is granted first after release.
- **Single request:** req 2 with pos 100 -> `mtr_valid_o=1`, `mtr_pos_o=100` one cycle later. Pulse `mtr_ack_i` -> `req_ack_o=4'b0100` one cycle later, `req_err_o=0`, `mtr_valid_o` low.
- **Round-robin:** all 4 requesters continuously valid (pos 10, 20, 30, 40), each motor ack returned 5 cycles after valid -> `grant_o` sequence 0,1,2,3,0, with `mtr_pos_o` matching each grant.
- **Range check:** req 1 with pos 241 -> `req_ack_o[1]` and `req_err_o[1]` pulse 1 cycle later, `mtr_valid_o` stays 0. Pos 240 is issued normally.
- **Reset in ISSUE:** assert `rst_i` while waiting for the motor ack -> `mtr_valid_o` drops the next cycle, no `req_ack_o`. After release, the same requester is reissued.
- **Timeout (`STPMTR_SCHED_TIMEOUT_EN`, TIMEOUT=8):** never ack the motor -> `req_ack_o` and `req_err_o` pulse 8 cycles after `mtr_valid_o` rose. Repeat with `mtr_ack_i` on cycle 8 -> ack only, no error.
